instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
// - Loads a program into the 32x16 instruction store while the CPU is held stalled.
// - Consumes a byte stream (from UART RX or debug port) on a valid/ready handshake.
// - Packs byte pairs into 16-bit instruction words and writes them sequentially from address 0.
// - Sits on the write side of the instruction memory; the PC-indexed read side stays unchanged.
// PARAMETERS
// - ADDR_W  5   instruction address width; depth = 2**ADDR_W words
// - DATA_W  16  instruction word width; fixed at 2*8, byte order high byte first
// PORTS
// - clk          in   1       single clock, rising edge
// - rst_n        in   1       asynchronous active-low reset
// - start        in   1       1-cycle pulse, begins a load session (ignored unless IDLE/ERR)
// - rx_data      in   8       stream byte
// - rx_valid     in   1       rx_data valid
// - rx_ready     out  1       loader accepts byte; transfer when rx_valid && rx_ready
// - mem_we       out  1       instruction memory write strobe (1 cycle per word)
// - mem_addr     out  ADDR_W  write address
// - mem_wdata    out  DATA_W  write data
// - cpu_hold     out  1       stall/reset request to the CPU core
// - load_done    out  1       1-cycle pulse, load completed with good checksum
// - load_err     out  1       sticky checksum error, cleared by next start
// - words_loaded out  ADDR_W+1  count of words written this session
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; internal count, checksum, hi-byte register cleared.
// - Stream frame: LEN byte N (0 means 2**ADDR_W; N > depth is clamped to depth),
//   then 2N data bytes (hi, lo per word), then 1 CSUM byte = XOR of all data bytes.
// - FSM: IDLE -start-> LEN -byte-> HI -byte-> LO -byte-> WR -> (HI if more words, else CSUM)
//   CSUM -byte-> DONE (match) | ERR (mismatch); DONE -> IDLE after 1 cycle.
// - rx_ready = 1 only in LEN, HI, LO, CSUM; registered, no combinational path from rx_valid.
// - A state waits indefinitely for rx_valid; there is no timeout.
// - WR: mem_we = 1 for exactly one cycle. mem_wdata = {hi, lo}. mem_addr = current word index.
//   Index increments after WR; words_loaded = index. The first write is at addr 0.
// - Latency: the write strobe is asserted in the cycle after the lo-byte transfer.
// - mem_addr and mem_wdata hold their last values outside WR.
// - cpu_hold: set on an accepted start; held through LEN..CSUM and in ERR; cleared entering DONE.
// - load_done: high only in the DONE cycle.
// - load_err: set entering ERR, cleared on start.
// - start in ERR restarts the session (count and checksum reset, load_err cleared).
// - start in any other non-IDLE state is ignored.
// - Checksum accumulates only on accepted data-byte transfers; the LEN byte is excluded.
// - Address wrap is impossible: N is clamped, so the index never exceeds 2**ADDR_W.
// - Async reset mid-session aborts immediately and returns to IDLE.
//   cpu_hold drops; partial words already written remain in memory.
// STRUCTURE
// - Shared header instr_mem_defs.vh: ADDR_W/DATA_W defaults, IMEM_DEPTH, and
//   FSM state encodings (IDLE, LEN, HI, LO, WR, CSUM, DONE, ERR).
// - Single module, one FSM plus datapath registers; no sub-module.
// - Top level muxes mem_* into the instruction store write port.
// TESTING
// - Reset: assert rst_n=0 mid-clock -> all outputs 0 asynchronously; state IDLE.
// - Good load: start; bytes 02,60,00,61,11,10 -> writes 0x6000@0, 0x6111@1; load_done 1 pulse;
//   words_loaded=2; cpu_hold 1 from cycle after start until DONE.
// - Bad checksum: same frame, CSUM=11 -> no load_done; load_err=1; cpu_hold stays 1;
//   a new start clears load_err.
// - Full and clamp: LEN=00, 64 data bytes -> 32 writes, addr 0..31, words_loaded=32.
//   Repeat with LEN=40 -> clamped to 32.
// - Backpressure: rx_valid toggled randomly with gaps -> identical writes.
//   No byte lost or duplicated; rx_ready low during WR.
// - Reset mid-load after 3 words -> outputs 0, IDLE. Next session loads correctly from addr 0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared constants, FSM state encoding and length-clamp helper for the instruction loader.
package instr_loader_pkg;

  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned DATA_W     = 2 * BYTE_W;
  localparam int unsigned IMEM_DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W      = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_WR   = 3'd4,
    ST_CSUM = 3'd5,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } state_e;

  // LEN byte 0 means a full store; anything above the depth is clamped to it.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [BYTE_W-1:0] n);
    if (n == '0 || 32'(n) > IMEM_DEPTH) return CNT_W'(IMEM_DEPTH);
    return CNT_W'(n);
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-store write port of the loader.
interface instr_loader_if;
  import instr_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Master: byte source and memory sink (UART/debug side, instruction store).
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  // Slave: the loader itself.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Loads a framed byte stream (LEN, hi/lo data pairs, XOR checksum) into the
// instruction store while holding the CPU stalled.
module instr_loader
  import instr_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  instr_loader_if.slave    bus,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] words_loaded
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  logic              rx_ready_q, rx_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic xfer_c;
  logic start_ok_c;

  assign xfer_c     = bus.rx_valid && rx_ready_q;
  assign start_ok_c = start && ((state_q == ST_IDLE) || (state_q == ST_ERR));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ERR: if (start_ok_c) state_d = ST_LEN;
      ST_LEN:          if (xfer_c) state_d = ST_HI;
      ST_HI:           if (xfer_c) state_d = ST_LO;
      ST_LO:           if (xfer_c) state_d = ST_WR;
      ST_WR:           state_d = ((idx_q + CNT_W'(1)) < len_q) ? ST_HI : ST_CSUM;
      ST_CSUM:         if (xfer_c) state_d = (bus.rx_data == csum_q) ? ST_DONE : ST_ERR;
      ST_DONE:         state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Output logic: decoded from the next state so every output is a register
  always_comb begin
    rx_ready_d  = state_d inside {ST_LEN, ST_HI, ST_LO, ST_CSUM};
    mem_we_d    = (state_d == ST_WR);
    cpu_hold_d  = state_d inside {ST_LEN, ST_HI, ST_LO, ST_WR, ST_CSUM, ST_ERR};
    load_done_d = (state_d == ST_DONE);
    load_err_d  = (state_d == ST_ERR);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if ((state_q == ST_LO) && xfer_c) begin
      mem_addr_d  = idx_q[ADDR_W-1:0];
      mem_wdata_d = {hi_q, bus.rx_data};
    end
  end

  // Datapath next values: word index, length, pending high byte, checksum
  always_comb begin
    idx_d  = idx_q;
    len_d  = len_q;
    hi_d   = hi_q;
    csum_d = csum_q;
    if (start_ok_c) begin
      idx_d  = '0;
      hi_d   = '0;
      csum_d = '0;
    end
    unique case (state_q)
      ST_LEN: if (xfer_c) len_d = clamp_len(bus.rx_data);
      ST_HI: if (xfer_c) begin
        hi_d   = bus.rx_data;
        csum_d = csum_q ^ bus.rx_data;
      end
      ST_LO:  if (xfer_c) csum_d = csum_q ^ bus.rx_data;
      ST_WR:  idx_d = idx_q + CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign words_loaded  = idx_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: framed loads checked against a frame-level model.
module tb_instr_loader;
  import instr_loader_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             cpu_hold;
  logic             load_done;
  logic             load_err;
  logic [CNT_W-1:0] words_loaded;

  instr_loader_if bus ();

  instr_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  int ready_viol = 0;
  int hold_viol  = 0;
  int done_cnt   = 0;

  // Observer: records every memory write and flags protocol violations
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wdata);
    end
    if (bus.mem_we && bus.rx_ready) ready_viol++;
    if ((bus.mem_we || bus.rx_ready) && !cpu_hold) hold_viol++;
    if (load_done) done_cnt++;
  end

  function automatic int clamp_n(input logic [7:0] len);
    if (len == 8'd0 || int'(len) > int'(IMEM_DEPTH)) return int'(IMEM_DEPTH);
    return int'(len);
  endfunction

  function automatic byte_q_t make_frame(input logic [7:0] len, input bit good);
    byte_q_t f;
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    f.push_back(len);
    for (int i = 0; i < 2 * clamp_n(len); i++) begin
      b = 8'($urandom_range(0, 255));
      f.push_back(b);
      x = x ^ b;
    end
    if (!good) x = x ^ 8'($urandom_range(1, 255));
    f.push_back(x);
    return f;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte; caller and return are both at a falling edge
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    bit sent;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    sent   = 1'b0;
    budget = 0;
    while (!sent && budget < 100) begin
      if (bus.rx_ready) begin
        @(posedge clk);
        sent = 1'b1;
        @(negedge clk);
      end else if (gaps && $urandom_range(0, 3) == 0) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        budget++;
      end else begin
        @(negedge clk);
        budget++;
      end
    end
    bus.rx_valid = 1'b0;
    checks++;
    if (!sent) begin
      errors++;
      $display("FAIL send_byte: byte %02h not accepted, got no ready within 100 cycles", b);
    end
  endtask

  // Sends a whole frame and checks writes, flags and counters against the model
  task automatic run_frame(input byte_q_t frame, input bit gaps, input bit poke_start,
                           input bit skip_start, input string name);
    int n;
    int d0;
    bit ok;
    logic [7:0] x;
    logic [DATA_W-1:0] exp_w[$];
    n = clamp_n(frame[0]);
    x = 8'h00;
    for (int i = 0; i < 2 * n; i++) x = x ^ frame[1 + i];
    for (int i = 0; i < n; i++) exp_w.push_back({frame[1 + 2 * i], frame[2 + 2 * i]});
    ok = (x == frame[2 * n + 1]);

    wa_q.delete();
    wd_q.delete();
    ready_viol = 0;
    hold_viol  = 0;
    d0 = done_cnt;

    if (!skip_start) begin
      do_start();
      checks++;
      if (cpu_hold !== 1'b1) begin
        errors++;
        $display("FAIL %s hold_after_start: got %b want 1", name, cpu_hold);
      end
    end

    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], gaps);
      if (poke_start && i == 1) do_start();
    end

    checks++;
    if (load_done !== ok) begin
      errors++;
      $display("FAIL %s load_done: got %b want %b", name, load_done, ok);
    end
    checks++;
    if (load_err !== !ok) begin
      errors++;
      $display("FAIL %s load_err: got %b want %b", name, load_err, !ok);
    end
    checks++;
    if (cpu_hold !== !ok) begin
      errors++;
      $display("FAIL %s hold_end: got %b want %b", name, cpu_hold, !ok);
    end
    checks++;
    if (words_loaded !== CNT_W'(n)) begin
      errors++;
      $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, n);
    end
    checks++;
    if (wd_q.size() != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, wd_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL %s write%0d: got %04h@%0d want %04h@%0d",
                   name, i, wd_q[i], wa_q[i], exp_w[i], i);
        end
      end
    end
    checks++;
    if (ready_viol != 0 || hold_viol != 0) begin
      errors++;
      $display("FAIL %s protocol: got ready_in_wr=%0d hold_drop=%0d want 0/0",
               name, ready_viol, hold_viol);
    end

    @(negedge clk);
    checks++;
    if (load_done !== 1'b0 || (done_cnt - d0) != (ok ? 1 : 0)) begin
      errors++;
      $display("FAIL %s done_pulse: got level=%b pulses=%0d want 0/%0d",
               name, load_done, done_cnt - d0, ok ? 1 : 0);
    end
    checks++;
    if (cpu_hold !== !ok || load_err !== !ok) begin
      errors++;
      $display("FAIL %s after_end: got hold=%b err=%b want %b/%b",
               name, cpu_hold, load_err, !ok, !ok);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (cpu_hold !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0 ||
        words_loaded !== '0 || bus.rx_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL %s zero_outputs: got hold=%b done=%b err=%b words=%0d rdy=%b we=%b want all 0",
               name, cpu_hold, load_done, load_err, words_loaded, bus.rx_ready, bus.mem_we);
    end
  endtask

  task automatic test_reset();
    #12;
    check_outputs_zero("reset");
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset mem_bus: got addr=%0d data=%04h want 0/0000", bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_load();
    byte_q_t f;
    f = '{8'h02, 8'h60, 8'h00, 8'h61, 8'h11, 8'h10};
    run_frame(f, 1'b0, 1'b0, 1'b0, "good");
    checks++;
    if (wd_q.size() < 2 || wd_q[0] !== 16'h6000 || wd_q[1] !== 16'h6111) begin
      errors++;
      $display("FAIL good literal_words: got %0d writes want 6000,6111", wd_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    byte_q_t f;
    f = '{8'h02, 8'h60, 8'h00, 8'h61, 8'h11, 8'h11};
    run_frame(f, 1'b0, 1'b0, 1'b0, "bad_csum");
    repeat (3) @(negedge clk);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum sticky: got err=%b hold=%b want 1/1", load_err, cpu_hold);
    end
    do_start();
    checks++;
    if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum restart: got err=%b hold=%b want 0/1", load_err, cpu_hold);
    end
    run_frame(make_frame(8'd4, 1'b1), 1'b0, 1'b0, 1'b1, "restart_load");
  endtask

  task automatic test_full_and_clamp();
    run_frame(make_frame(8'h00, 1'b1), 1'b0, 1'b0, 1'b0, "full");
    run_frame(make_frame(8'h40, 1'b1), 1'b0, 1'b0, 1'b0, "clamp");
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 6; k++) begin
      run_frame(make_frame(8'($urandom_range(1, 40)), ($urandom_range(0, 3) != 0)),
                1'b1, (k == 0), 1'b0, "backpressure");
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++)
      run_frame(make_frame(8'($urandom_range(1, 8)), 1'b1), 1'b0, 1'b0, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid_load();
    byte_q_t f;
    f = make_frame(8'd5, 1'b1);
    wa_q.delete();
    wd_q.delete();
    do_start();
    for (int i = 0; i < 7; i++) send_byte(f[i], 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    checks++;
    if (wd_q.size() != 3) begin
      errors++;
      $display("FAIL mid_reset partial_writes: got %0d want 3", wd_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== {f[1 + 2 * i], f[2 + 2 * i]}) begin
          errors++;
          $display("FAIL mid_reset write%0d: got %04h@%0d want %04h@%0d",
                   i, wd_q[i], wa_q[i], {f[1 + 2 * i], f[2 + 2 * i]}, i);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(make_frame(8'($urandom_range(1, 32)), 1'b1), 1'b1, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_full_and_clamp();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
